// File: rtl/dual_row_shift_pkg.sv
// Shared types and constants for the dual-row BRAM loader.
package dual_row_shift_pkg;
  localparam int unsigned WORDS_PER_ROW = 16;
  localparam int unsigned ROW_W         = 512;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned ROWNUM_W      = 9;
  localparam int unsigned ADDR_W        = 13;
  localparam int unsigned WORDIDX_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH1 = 2'd1,
    ST_FETCH2 = 2'd2,
    ST_DONE   = 2'd3
  } state_e;
endpackage

// File: rtl/dual_row_shift_rd_512b_from_bram.sv
// Reads one 16-word row from BRAM into a 512-bit buffer using the trig/done
// handshake; pulses o_row_done once the last word has been captured.
module rd_512b_from_bram
  import dual_row_shift_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_start,
  input  logic [ROWNUM_W-1:0] i_row,
  output logic                o_row_done,
  output logic [ROW_W-1:0]    o_buf,
  output logic [ADDR_W-1:0]   o_rd_from_bram_addr,
  output logic                o_rd_from_bram_trig,
  input  logic [WORD_W-1:0]   i_rd_from_bram_data,
  input  logic                i_rd_from_bram_done
);
  logic [ROWNUM_W-1:0]  r_row;
  logic [WORDIDX_W-1:0] r_word;
  logic                 r_trig;
  logic                 r_gap;
  logic                 r_row_done;
  logic [ROW_W-1:0]     r_buf;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_row      <= '0;
      r_word     <= '0;
      r_trig     <= 1'b0;
      r_gap      <= 1'b0;
      r_row_done <= 1'b0;
      r_buf      <= '0;
    end else begin
      r_row_done <= 1'b0;
      if (i_start) begin
        r_row  <= i_row;
        r_word <= '0;
        r_trig <= 1'b1;
        r_gap  <= 1'b0;
      end else if (r_trig && i_rd_from_bram_done) begin
        r_buf[{r_word, 5'd0} +: WORD_W] <= i_rd_from_bram_data;
        r_trig <= 1'b0;
        if (r_word == WORDIDX_W'(WORDS_PER_ROW - 1)) begin
          r_row_done <= 1'b1;
        end else begin
          r_word <= r_word + 4'd1;
          r_gap  <= 1'b1;
        end
      end else if (r_gap) begin
        // trig stays low for exactly this one cycle between words
        r_gap  <= 1'b0;
        r_trig <= 1'b1;
      end
    end
  end

  assign o_row_done          = r_row_done;
  assign o_buf               = r_buf;
  assign o_rd_from_bram_addr = {r_row, r_word};
  assign o_rd_from_bram_trig = r_trig;
endmodule

// File: rtl/dual_row_shift.sv
// Two-row BRAM window: loads (init) or shifts-and-loads a pair of 512-bit rows.
// Optional debug ports enabled by defining DUAL_ROW_SHIFT_DEBUG_EN.
module dual_row_shift
  import dual_row_shift_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_trig_rd,
  output logic                o_done,
  input  logic [ROWNUM_W-1:0] i_row_num_to_read,
  input  logic [ROWNUM_W-1:0] i_row_num_to_initial_setup,
  input  logic                i_init_en,
  output logic [ROW_W-1:0]    o_1st_row_512b,
  output logic [ROW_W-1:0]    o_2nd_row_512b,
  output logic [ADDR_W-1:0]   u_rd_512b_from_bram_o_rd_from_bram_addr,
  input  logic [WORD_W-1:0]   u_rd_512b_from_bram_i_rd_from_bram_data,
  output logic                u_rd_512b_from_bram_o_rd_from_bram_trig,
  input  logic                u_rd_512b_from_bram_i_rd_from_bram_done
`ifdef DUAL_ROW_SHIFT_DEBUG_EN
  ,
  output logic [7:0]          o_dbg_sm_state,
  output logic [WORD_W-1:0]   o_dbg_bram_data
`endif
);
  state_e              r_state;
  state_e              w_next;
  logic                r_init_en;
  logic [ROWNUM_W-1:0] r_rd_row;
  logic [ROWNUM_W-1:0] r_setup_row;
  logic                r_start;
  logic [ROWNUM_W-1:0] w_row;
  logic                w_row_done;
  logic [ROW_W-1:0]    w_buf;
  logic [ROW_W-1:0]    r_1st_row;
  logic [ROW_W-1:0]    r_2nd_row;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (i_trig_rd) w_next = i_init_en ? ST_FETCH1 : ST_FETCH2;
      ST_FETCH1: if (w_row_done) w_next = ST_FETCH2;
      ST_FETCH2: if (w_row_done) w_next = ST_DONE;
      ST_DONE:   if (!i_trig_rd) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_done = (r_state == ST_DONE);
    w_row  = (r_state == ST_FETCH1) ? r_setup_row : r_rd_row;
  end

  // Start pulses are issued one cycle after entering a fetch state so the
  // row mux above already reflects the new state.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_init_en   <= 1'b0;
      r_rd_row    <= '0;
      r_setup_row <= '0;
      r_start     <= 1'b0;
      r_1st_row   <= '0;
      r_2nd_row   <= '0;
    end else begin
      r_start <= 1'b0;
      if (r_state == ST_IDLE && i_trig_rd) begin
        r_init_en   <= i_init_en;
        r_rd_row    <= i_row_num_to_read;
        r_setup_row <= i_row_num_to_initial_setup;
        r_start     <= 1'b1;
      end else if (r_state == ST_FETCH1 && w_row_done) begin
        r_1st_row <= w_buf;
        r_start   <= 1'b1;
      end else if (r_state == ST_FETCH2 && w_row_done) begin
        r_2nd_row <= w_buf;
        if (!r_init_en) r_1st_row <= r_2nd_row;
      end
    end
  end

  assign o_1st_row_512b = r_1st_row;
  assign o_2nd_row_512b = r_2nd_row;

  rd_512b_from_bram u_rd_512b_from_bram (
    .i_clk               (i_clk),
    .i_rstn              (i_rstn),
    .i_start             (r_start),
    .i_row               (w_row),
    .o_row_done          (w_row_done),
    .o_buf               (w_buf),
    .o_rd_from_bram_addr (u_rd_512b_from_bram_o_rd_from_bram_addr),
    .o_rd_from_bram_trig (u_rd_512b_from_bram_o_rd_from_bram_trig),
    .i_rd_from_bram_data (u_rd_512b_from_bram_i_rd_from_bram_data),
    .i_rd_from_bram_done (u_rd_512b_from_bram_i_rd_from_bram_done)
  );

`ifdef DUAL_ROW_SHIFT_DEBUG_EN
  logic [WORD_W-1:0] r_dbg_bram_data;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_dbg_bram_data <= '0;
    end else if (u_rd_512b_from_bram_o_rd_from_bram_trig &&
                 u_rd_512b_from_bram_i_rd_from_bram_done) begin
      r_dbg_bram_data <= u_rd_512b_from_bram_i_rd_from_bram_data;
    end
  end

  assign o_dbg_sm_state  = {6'd0, r_state};
  assign o_dbg_bram_data = r_dbg_bram_data;
`endif
endmodule

// File: tb/tb_dual_row_shift.sv
// Self-checking bench for dual_row_shift with a behavioural BRAM and row model.
module tb_dual_row_shift;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         trig = 1'b0;
  logic         init_en = 1'b0;
  logic [8:0]   rd_row = '0;
  logic [8:0]   setup_row = '0;
  logic         done;
  logic [511:0] o1, o2;
  logic [12:0]  bram_addr;
  logic [31:0]  bram_data;
  logic         bram_trig;
  logic         bram_done;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  dual_row_shift dut (
    .i_clk                                   (clk),
    .i_rstn                                  (rstn),
    .i_trig_rd                               (trig),
    .o_done                                  (done),
    .i_row_num_to_read                       (rd_row),
    .i_row_num_to_initial_setup              (setup_row),
    .i_init_en                               (init_en),
    .o_1st_row_512b                          (o1),
    .o_2nd_row_512b                          (o2),
    .u_rd_512b_from_bram_o_rd_from_bram_addr (bram_addr),
    .u_rd_512b_from_bram_i_rd_from_bram_data (bram_data),
    .u_rd_512b_from_bram_o_rd_from_bram_trig (bram_trig),
    .u_rd_512b_from_bram_i_rd_from_bram_done (bram_done)
  );

  // BRAM: done is a one-cycle pulse two cycles after trig; data = address.
  int unsigned bm_cnt = 0;
  int unsigned unstable_cnt = 0;
  logic        prev_trig = 1'b0;
  logic [12:0] prev_addr = '0;
  logic [12:0] addr_log[$];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bm_cnt    <= 0;
      bram_done <= 1'b0;
      bram_data <= '0;
      prev_trig <= 1'b0;
    end else begin
      prev_trig <= bram_trig;
      prev_addr <= bram_addr;
      if (bram_trig && prev_trig && bram_addr != prev_addr) unstable_cnt <= unstable_cnt + 1;
      if (!bram_trig) begin
        bm_cnt    <= 0;
        bram_done <= 1'b0;
      end else if (bram_done) begin
        bram_done <= 1'b0;
      end else if (bm_cnt == 1) begin
        bram_done <= 1'b1;
        bram_data <= {19'h0, bram_addr};
        addr_log.push_back(bram_addr);
      end else begin
        bm_cnt <= bm_cnt + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] row_img(input logic [8:0] r);
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = 32'(r) * 32'd16 + 32'(k);
    return v;
  endfunction

  logic [511:0] m1 = '0;
  logic [511:0] m2 = '0;

  task automatic run_op(input logic ie, input logic [8:0] su, input logic [8:0] rd,
                        input int hold, input logic scramble, input string tag,
                        output int n_reqs, output logic [12:0] last_addr);
    logic [511:0] new1, new2, old1, old2;
    logic [12:0]  exp_addr[$];
    int           base, partial, unstable0, bad_addr;
    logic         got;
    old1 = m1; old2 = m2;
    new1 = ie ? row_img(su) : old2;
    new2 = row_img(rd);
    if (ie) for (int k = 0; k < 16; k++) exp_addr.push_back(13'(su * 16 + k));
    for (int k = 0; k < 16; k++) exp_addr.push_back(13'(rd * 16 + k));
    base = addr_log.size();
    unstable0 = unstable_cnt;
    partial = 0;
    got = 1'b0;
    @(negedge clk);
    init_en = ie; setup_row = su; rd_row = rd; trig = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (scramble && cyc == 5) begin
        setup_row = 9'($urandom); rd_row = 9'($urandom); init_en = ~ie;
      end
      if (!((o1 === old1 || o1 === new1) && (o2 === old2 || o2 === new2))) partial++;
      if (done) begin got = 1'b1; break; end
    end
    chk({tag, ".done_seen"}, 512'(got), 512'(1));
    chk({tag, ".no_partial_rows"}, 512'(partial), 512'(0));
    chk({tag, ".row1"}, o1, new1);
    chk({tag, ".row2"}, o2, new2);
    n_reqs = addr_log.size() - base;
    chk({tag, ".req_count"}, 512'(n_reqs), 512'(exp_addr.size()));
    bad_addr = 0;
    for (int i = 0; i < exp_addr.size() && i < n_reqs; i++)
      if (addr_log[base + i] !== exp_addr[i]) bad_addr++;
    chk({tag, ".addr_seq_errors"}, 512'(bad_addr), 512'(0));
    chk({tag, ".addr_stable"}, 512'(unstable_cnt - unstable0), 512'(0));
    last_addr = (n_reqs > 0) ? addr_log[addr_log.size() - 1] : 13'h0;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk({tag, ".done_held"}, 512'(done), 512'(1));
      chk({tag, ".no_restart"}, 512'(addr_log.size() - base), 512'(n_reqs));
    end
    trig = 1'b0;
    @(negedge clk);
    chk({tag, ".done_fell"}, 512'(done), 512'(0));
    repeat (3) @(negedge clk);
    chk({tag, ".idle_quiet"}, 512'(bram_trig), 512'(0));
    m1 = new1; m2 = new2;
  endtask

  typedef struct {
    logic        ie;
    logic [8:0]  su;
    logic [8:0]  rd;
    int          hold;
    logic        scr;
    int          exp_reqs;
    logic [12:0] exp_last;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    int          nr;
    logic [12:0] la;
    int          base, cyc;

    vecs.push_back('{1'b0, 9'h000, 9'h1FF, 0, 1'b0, 16, 13'h1FFF});
    vecs.push_back('{1'b1, 9'h1FF, 9'h000, 0, 1'b0, 32, 13'h000F});
    vecs.push_back('{1'b1, 9'h000, 9'h1FF, 0, 1'b0, 32, 13'h1FFF});
    vecs.push_back('{1'b1, 9'h123, 9'h045, 6, 1'b1, 32, 13'h045F});
    vecs.push_back('{1'b0, 9'h0AA, 9'h155, 4, 1'b1, 16, 13'h155F});
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v.ie = 1'($urandom_range(0, 1));
      v.su = 9'($urandom);
      v.rd = 9'($urandom);
      v.hold = int'($urandom_range(0, 3));
      v.scr = 1'($urandom_range(0, 1));
      v.exp_reqs = v.ie ? 32 : 16;
      v.exp_last = {v.rd, 4'hF};
      vecs.push_back(v);
    end

    #12;
    chk("reset.done", 512'(done), 512'(0));
    chk("reset.trig", 512'(bram_trig), 512'(0));
    chk("reset.addr", 512'(bram_addr), 512'(0));
    chk("reset.row1", o1, '0);
    chk("reset.row2", o2, '0);
    @(negedge clk);
    rstn = 1'b1;

    run_op(1'b1, 9'h00A, 9'h00B, 0, 1'b0, "init_0A_0B", nr, la);
    chk("init_0A_0B.last_addr", 512'(la), 512'(13'h0BF));
    run_op(1'b0, 9'h000, 9'h00C, 0, 1'b0, "shift_0C", nr, la);
    chk("shift_0C.req_count_tbl", 512'(nr), 512'(16));

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_op(vecs[i].ie, vecs[i].su, vecs[i].rd, vecs[i].hold, vecs[i].scr, tag, nr, la);
      chk({tag, ".reqs_tbl"}, 512'(nr), 512'(vecs[i].exp_reqs));
      chk({tag, ".last_addr_tbl"}, 512'(la), 512'(vecs[i].exp_last));
    end

    // Reset pulsed while the second row is being fetched.
    base = addr_log.size();
    @(negedge clk);
    init_en = 1'b1; setup_row = 9'h055; rd_row = 9'h066; trig = 1'b1;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (addr_log.size() - base >= 20) break;
    end
    chk("rst_mid.reached_fetch2", 512'(addr_log.size() - base >= 20), 512'(1));
    chk("rst_mid.row1_loaded", o1, row_img(9'h055));
    rstn = 1'b0; trig = 1'b0;
    #1;
    chk("rst_mid.done", 512'(done), 512'(0));
    chk("rst_mid.trig", 512'(bram_trig), 512'(0));
    chk("rst_mid.addr", 512'(bram_addr), 512'(0));
    chk("rst_mid.row1", o1, '0);
    chk("rst_mid.row2", o2, '0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    m1 = '0; m2 = '0;
    run_op(1'b1, 9'h077, 9'h088, 2, 1'b0, "after_rst", nr, la);
    run_op(1'b0, 9'h000, 9'h099, 0, 1'b0, "after_rst_shift", nr, la);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dual_row_shift.md
DUAL_ROW_SHIFT -- requirements
Module: dual_row_shift

Interface
REQ-001 Parameters: none; all widths are fixed by this document.
REQ-002 i_clk  in  1  single clock; all logic on rising edge.
REQ-003 i_rstn  in  1  reset, asynchronous, active-low.
REQ-004 i_trig_rd  in  1  start request, level; sampled only in IDLE.
REQ-005 o_done  out  1  operation complete; 4-phase acknowledge.
REQ-006 i_row_num_to_read  in  9  row to load into 2nd-row register.
REQ-007 i_row_num_to_initial_setup  in  9  row to load into 1st-row register when i_init_en=1.
REQ-008 i_init_en  in  1  1 = load both rows; 0 = shift row 2 into row 1, then load row 2.
REQ-009 o_1st_row_512b  out  512  1st (older) row register.
REQ-010 o_2nd_row_512b  out  512  2nd (newer) row register.
REQ-011 u_rd_512b_from_bram_o_rd_from_bram_addr  out  13  BRAM word address = {row[8:0], word[3:0]}.
REQ-012 u_rd_512b_from_bram_i_rd_from_bram_data  in  32  BRAM read data; valid while done=1.
REQ-013 u_rd_512b_from_bram_o_rd_from_bram_trig  out  1  BRAM read request.
REQ-014 u_rd_512b_from_bram_i_rd_from_bram_done  in  1  BRAM read acknowledge.

Function
REQ-015 A row is 16 x 32-bit words; word k (address row*16+k) maps to bits [32k+31:32k], word 0 at the LSBs.
REQ-016 BRAM handshake: drive the address, hold trig=1 with a stable address until done=1; capture data in the cycle done=1; drop trig for exactly one cycle; then request the next word.
REQ-017 State machine: IDLE, FETCH1, FETCH2, DONE.
- IDLE -> FETCH1 on i_trig_rd=1 with i_init_en=1.
- IDLE -> FETCH2 on i_trig_rd=1 with i_init_en=0.
REQ-018 i_row_num_to_read, i_row_num_to_initial_setup and i_init_en are latched on the IDLE exit cycle; later changes are ignored until the next operation.
REQ-019 FETCH1 reads the 16 words of the setup row into a 512-bit buffer; after word 15 it commits the buffer to o_1st_row_512b and goes to FETCH2.
REQ-020 FETCH2 reads the 16 words of the read row into the buffer, then goes to DONE. After word 15 it commits, in one cycle:
- the buffer to o_2nd_row_512b;
- if the latched i_init_en=0, the old o_2nd_row_512b to o_1st_row_512b at the same time.
REQ-021 Row outputs change only at commit and never show partially filled rows.
REQ-022 DONE holds o_done=1 until i_trig_rd=0, then returns to IDLE with o_done=0; o_done is 0 in all other states.
REQ-023 i_trig_rd asserted while busy (not IDLE) has no effect.
REQ-024 No address wrap: row 511, word 15 gives 0x1FFF.
REQ-025 Latency: in the init case, exactly 32 BRAM requests; in the shift case, exactly 16; o_done rises the cycle after the final commit.

Reset
REQ-026 While i_rstn=0: state IDLE, o_done=0, trig=0, addr=0, both row outputs and the buffer all zeros, latched inputs cleared.
REQ-027 Reset asserted mid-operation aborts the operation immediately; no partial commit survives.

Configuration
REQ-028 With DUAL_ROW_SHIFT_DEBUG_EN defined, the module adds two outputs:
- o_dbg_sm_state (8 bits): IDLE=0, FETCH1=1, FETCH2=2, DONE=3;
- o_dbg_bram_data (32 bits): last captured BRAM word, reset 0.
REQ-029 Without DUAL_ROW_SHIFT_DEBUG_EN these ports are absent; function is otherwise identical.

Structure
REQ-030 A shared package holds the state enum and its encodings, WORDS_PER_ROW=16, ROW_W=512, WORD_W=32, ROWNUM_W=9 and ADDR_W=13.
REQ-031 One sub-module, rd_512b_from_bram, holds the BRAM handshake, word counter and 512-bit buffer. It is started by a row number and returns a row-done pulse.

Verification (BRAM model: data = {19'h0, addr}, done is a 1-cycle pulse 2 cycles after trig)
REQ-032 Init, setup=0x0A, read=0x0B -> addresses 0x0A0..0x0AF then 0x0B0..0x0BF. Expected result: 1st-row word k = 0xA0+k and 2nd-row word k = 0xB0+k.
REQ-033 Trig held until o_done, then dropped -> o_done falls the next cycle.
REQ-034 Then shift, read=0x0C, i_init_en=0 -> only 0x0C0..0x0CF are read. Expected result: 1st row = previous 2nd row (0xB0+k), 2nd row word k = 0xC0+k.
REQ-035 Boundary: read=0x1FF -> addresses 0x1FF0..0x1FFF, no wrap.
REQ-036 Reset pulsed during FETCH2 -> all outputs zero, IDLE; a new trigger then completes normally.
REQ-037 Row inputs changed mid-operation and i_trig_rd kept high through DONE -> latched rows are used; o_done stays 1 and no restart occurs until i_trig_rd falls.
